wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Write-side master for the integer register file; the only block that drives its write port.
- Arbitrates one result per cycle between the single-cycle ALU result path and the multi-cycle memory/load result path.
- Drives registered write_enable/write_addr/data_in into the register file.
- Maintains a pending-write scoreboard so decode can stall on RAW hazards against in-flight destinations.

Parameters:
XLEN, 32, data width of results and register file entries
NREGS, 32, number of architectural registers (address width = clog2(NREGS) = 5)
STARVE_LIMIT, 4, consecutive cycles a valid memory result may lose arbitration before it is forced to win

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  5  destination register of the issued instruction
rs1_addr  in  5  decode source 1 address for hazard check
rs2_addr  in  5  decode source 2 address for hazard check
raw_stall  out  1  combinational; a source register has a pending write
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result available
mem_ready  out  1  load result accepted this cycle
mem_rd  in  5  load destination register
mem_data  in  XLEN  load result
write_enable  out  1  register file write strobe (registered)
write_addr  out  5  register file write address (registered)
data_in  out  XLEN  register file write data (registered)
pending  out  NREGS  scoreboard bit vector; bit i set means xi has an outstanding write

Behaviour:
- Reset (rst_n low, asynchronous): write_enable=0, write_addr=0, data_in=0, pending=0, starve counter=0.
- Handshake: a transfer happens on a path in any cycle where valid && ready. The source holds rd/data stable while valid && !ready.
- Arbitration, evaluated combinationally each cycle:
  - Default: ALU wins.
  - mem_ready = mem_valid && (!alu_valid || starve_cnt == STARVE_LIMIT).
  - alu_ready = !(mem_valid && starve_cnt == STARVE_LIMIT).
  - At most one transfer per cycle.
- Starve counter:
  - Increments when mem_valid && !mem_ready.
  - Clears on any mem transfer, or when mem_valid=0.
  - Saturates at STARVE_LIMIT.
- Write port, one-cycle latency:
  - A transfer in cycle N registers rd/data at the end of N.
  - write_enable=1 during N+1; the register file commits at the end of N+1.
  - With no transfer, write_enable=0 next cycle; write_addr and data_in hold their previous values.
- x0 rule: a transfer with rd==0 is accepted (ready follows the normal rules) but produces write_enable=0 and no scoreboard effect.
- Scoreboard:
  - Set pending[issue_rd] at the end of a cycle with issue_valid && issue_rd!=0.
  - Clear pending[write_addr] at the end of a cycle with write_enable=1.
  - Simultaneous set and clear of the same index: set wins, because the newer instruction owns the register.
  - pending[0] is constantly 0.
- Hazard check:
  - raw_stall = (rs1_addr!=0 && pending[rs1_addr]) || (rs2_addr!=0 && pending[rs2_addr]).
  - No forwarding. A register is usable by decode from the cycle after its write commits.
- Reset mid-operation: in-flight output-register contents are dropped, pending clears, and the counter clears. Upstream is responsible for flushing sources.

Decomposition:
- Shared cpu package: XLEN, REG_ADDR_W=5, NREGS, and a wb_req_t struct {rd, data}. The load unit and ALU stage reuse them.
- One sub-module: wb_scoreboard. It holds the pending vector with its set/clear/priority rules and the raw_stall lookup.
- Arbitration, starve counter and output register stay in wb_arbiter.

Test Plan:
1. Reset with rst_n=0 mid-cycle → all outputs 0 immediately; pending=0 after release.
2. ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle N → alu_ready=1 in N; write_enable=1, write_addr=5, data_in=0xDEADBEEF in N+1; write_enable=0 in N+2.
3. Contention and starvation: alu_valid and mem_valid both held high with mem_rd=7, mem_data=0x1234 → ALU wins 4 cycles, mem_ready=0 throughout; in the 5th cycle mem_ready=1 and alu_ready=0; the next cycle writes x7=0x1234.
4. Scoreboard: issue rd=3, then rs1_addr=3 → raw_stall=1 until the cycle after write_enable with write_addr=3; issue rd=3 in the same cycle as that commit → pending[3] stays 1.
5. x0: alu_rd=0, alu_data=0xFFFFFFFF → alu_ready=1, write_enable stays 0, pending unchanged; issue_rd=0 never sets pending, and rs1_addr=0 never stalls.
6. Back-to-back: ALU transfers to x1, x2, x3 in consecutive cycles → three consecutive write_enable pulses with matching addr/data; pending bits clear in order.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU definitions for the write-back path: widths, register count and
// the result request record used by the ALU stage and the load unit.
package wb_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int NREGS        = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for the integer register file, plus the RAW hazard
// lookup that decode uses to stall.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NREGS = wb_arbiter_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [NREGS-1:0]      pending,
  output logic                  raw_stall
);

  logic [NREGS-1:0] pending_next;

  // A newer issue to the same register outranks the commit of the older write.
  always_comb begin
    pending_next = pending;
    if (clr_valid) pending_next[clr_idx] = 1'b0;
    if (set_valid && set_idx != '0) pending_next[set_idx] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  assign raw_stall = (rs1_addr != '0 && pending[rs1_addr]) ||
                     (rs2_addr != '0 && pending[rs2_addr]);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one of the ALU and load results per cycle, drives the
// register file write port one cycle later, and tracks in-flight destinations.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN         = wb_arbiter_pkg::XLEN,
  parameter int NREGS        = wb_arbiter_pkg::NREGS,
  parameter int STARVE_LIMIT = wb_arbiter_pkg::STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  raw_stall,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       data_in,
  output logic [NREGS-1:0]      pending
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]         starve_cnt;
  logic                  starved;
  logic                  alu_xfer;
  logic                  mem_xfer;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  // ALU has priority unless the load result has already waited its full budget.
  assign starved   = (starve_cnt == CW'(STARVE_LIMIT));
  assign mem_ready = mem_valid && (!alu_valid || starved);
  assign alu_ready = !(mem_valid && starved);
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_xfer) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (mem_xfer) begin
      sel_valid = 1'b1;
      sel_rd    = mem_rd;
      sel_data  = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!mem_valid || mem_xfer) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Writes to x0 are consumed here so the register file never sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      data_in      <= '0;
    end else begin
      write_enable <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        write_addr <= sel_rd;
        data_in    <= sel_data;
      end
    end
  end

  wb_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_valid(issue_valid),
    .set_idx  (issue_rd),
    .clr_valid(write_enable),
    .clr_idx  (write_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .pending  (pending),
    .raw_stall(raw_stall)
  );

endmodule
